mem_wb_stage: RTL and testbench

MEM_WB_STAGE -- requirements
Module: mem_wb_stage

---
 rtl/pipe_pkg.sv | 20 ++
 rtl/pipe_slot.sv | 28 ++
 rtl/mem_wb_stage.sv | 197 +++++++++++++++++++
 tb/tb_mem_wb_stage.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared types for the MEM/WB pipeline register.
//   wb_payload_t      : packed write-back payload at the default widths (XLEN=32, RD_W=5)
//   occ_e             : slot occupancy (EMPTY, ONE, FULL)
//   NOP_INSTR_DEFAULT : instruction word shown while the output slot holds a bubble
package pipe_pkg;

  localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0033;

  typedef enum logic [1:0] {EMPTY, ONE, FULL} occ_e;

  typedef struct packed {
    logic        reg_write;
    logic [1:0]  result_src;
    logic [4:0]  rd;
    logic [31:0] alu_result;
    logic [31:0] pc_plus4;
    logic [31:0] instr;
  } wb_payload_t;

endpackage

// File: rtl/pipe_slot.sv
// One payload storage slot: enable-loaded register with asynchronous active-low reset.
//   clk   : clock
//   n_rst : asynchronous active-low reset, loads RstVal
//   en    : load d on the next rising edge
//   d     : payload in
//   q     : stored payload
module pipe_slot
  import pipe_pkg::*;
#(
  parameter type T      = wb_payload_t,
  parameter T    RstVal = T'('0)
) (
  input  logic clk,
  input  logic n_rst,
  input  logic en,
  input  T     d,
  output T     q
);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      q <= RstVal;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register with valid/ready handshake on both sides.
// Build option: define MEM_WB_SKID_EN to add a skid slot so that ready_m is a flop output
// independent of ready_w; without it ready_m = ~valid_w | ready_w (single slot, full rate).
// Ports:
//   clk, n_rst            : clock, asynchronous active-low reset
//   flush                 : drop every held and incoming payload this cycle
//   valid_m / ready_m     : M-side handshake
//   *M                    : M-side payload fields
//   valid_w / ready_w     : W-side handshake
//   *W                    : registered payload; RegWriteW=0 and InstrW=NOP_INSTR when !valid_w
module mem_wb_stage
  import pipe_pkg::*;
#(
  parameter int unsigned      XLEN      = 32,
  parameter int unsigned      RD_W      = 5,
  parameter logic [XLEN-1:0]  NOP_INSTR = XLEN'(NOP_INSTR_DEFAULT)
) (
  input  logic            clk,
  input  logic            n_rst,
  input  logic            flush,
  input  logic            valid_m,
  output logic            ready_m,
  input  logic            RegWriteM,
  input  logic [1:0]      ResultSrcM,
  input  logic [RD_W-1:0] RdM,
  input  logic [XLEN-1:0] ALUResultM,
  input  logic [XLEN-1:0] PC_plus4M,
  input  logic [XLEN-1:0] InstrM,
  output logic            valid_w,
  input  logic            ready_w,
  output logic            RegWriteW,
  output logic [1:0]      ResultSrcW,
  output logic [RD_W-1:0] RdW,
  output logic [XLEN-1:0] ALUResultW,
  output logic [XLEN-1:0] PC_plus4W,
  output logic [XLEN-1:0] InstrW
);

  // Same layout as wb_payload_t, sized by this instance's parameters.
  typedef struct packed {
    logic            reg_write;
    logic [1:0]      result_src;
    logic [RD_W-1:0] rd;
    logic [XLEN-1:0] alu_result;
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] instr;
  } payload_t;

  localparam payload_t RstPayload = '{
    reg_write:  1'b0,
    result_src: 2'b00,
    rd:         '0,
    alu_result: '0,
    pc_plus4:   '0,
    instr:      NOP_INSTR
  };

  payload_t in_pl, o_d, o_q;
  logic     o_en;
  occ_e     occ_q, occ_d;
  logic     xfer_in, xfer_out;

  assign in_pl = '{
    reg_write:  RegWriteM,
    result_src: ResultSrcM,
    rd:         RdM,
    alu_result: ALUResultM,
    pc_plus4:   PC_plus4M,
    instr:      InstrM
  };

  assign valid_w  = (occ_q != EMPTY);
  // Flush wins over a coincident input: the payload is discarded.
  assign xfer_in  = valid_m & ready_m & ~flush;
  assign xfer_out = valid_w & ready_w;

`ifdef MEM_WB_SKID_EN
  payload_t s_q;
  logic     s_en;
  logic     ready_q;

  always_comb begin
    occ_d = occ_q;
    o_en  = 1'b0;
    o_d   = in_pl;
    s_en  = 1'b0;
    if (flush) begin
      occ_d = EMPTY;
    end else begin
      unique case (occ_q)
        EMPTY: begin
          if (xfer_in) begin
            o_en  = 1'b1;
            occ_d = ONE;
          end
        end
        ONE: begin
          if (xfer_in && xfer_out) begin
            o_en = 1'b1;
          end else if (xfer_in) begin
            // W stalled: park the new payload behind the output slot.
            s_en  = 1'b1;
            occ_d = FULL;
          end else if (xfer_out) begin
            occ_d = EMPTY;
          end
        end
        FULL: begin
          if (xfer_out) begin
            o_en  = 1'b1;
            o_d   = s_q;
            occ_d = ONE;
          end
        end
        default: occ_d = EMPTY;
      endcase
    end
  end

  pipe_slot #(
    .T      (payload_t),
    .RstVal (RstPayload)
  ) u_slot_s (
    .clk   (clk),
    .n_rst (n_rst),
    .en    (s_en),
    .d     (in_pl),
    .q     (s_q)
  );

  // Registered ready: low only while both slots are occupied.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      ready_q <= 1'b0;
    end else begin
      ready_q <= (occ_d != FULL);
    end
  end

  // ready_q is only low in FULL, where valid_w is high, so this raises ready during a flush
  // without opening it during reset.
  assign ready_m = ready_q | (flush & valid_w);
`else
  logic alive_q;

  always_comb begin
    occ_d = occ_q;
    o_d   = in_pl;
    o_en  = xfer_in;
    if (flush) begin
      occ_d = EMPTY;
    end else if (xfer_in) begin
      occ_d = ONE;
    end else if (xfer_out) begin
      occ_d = EMPTY;
    end
  end

  // Holds ready low until the first edge after reset release.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      alive_q <= 1'b0;
    end else begin
      alive_q <= 1'b1;
    end
  end

  assign ready_m = alive_q & (~valid_w | ready_w | flush);
`endif

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      occ_q <= EMPTY;
    end else begin
      occ_q <= occ_d;
    end
  end

  pipe_slot #(
    .T      (payload_t),
    .RstVal (RstPayload)
  ) u_slot_o (
    .clk   (clk),
    .n_rst (n_rst),
    .en    (o_en),
    .d     (o_d),
    .q     (o_q)
  );

  assign RegWriteW  = o_q.reg_write & valid_w;
  assign ResultSrcW = o_q.result_src;
  assign RdW        = o_q.rd;
  assign ALUResultW = o_q.alu_result;
  assign PC_plus4W  = o_q.pc_plus4;
  assign InstrW     = valid_w ? o_q.instr : NOP_INSTR;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Scoreboard bench for mem_wb_stage. Accepted payloads are queued by the driver; the monitor
// compares the W side with the queue head every cycle and retires it on each output transfer.
module tb_mem_wb_stage;

  localparam logic [31:0] Nop = 32'h0000_0033;
`ifdef MEM_WB_SKID_EN
  localparam bit Skid = 1'b1;
`else
  localparam bit Skid = 1'b0;
`endif

  typedef struct packed {
    logic        rw;
    logic [1:0]  rs;
    logic [4:0]  rd;
    logic [31:0] alu;
    logic [31:0] pc4;
    logic [31:0] instr;
  } pl_t;

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic        flush = 1'b0;
  logic        valid_m = 1'b0;
  logic        ready_w = 1'b0;
  logic        ready_m, valid_w;
  logic        RegWriteM = 1'b0;
  logic [1:0]  ResultSrcM = '0;
  logic [4:0]  RdM = '0;
  logic [31:0] ALUResultM = '0, PC_plus4M = '0, InstrM = '0;
  logic        RegWriteW;
  logic [1:0]  ResultSrcW;
  logic [4:0]  RdW;
  logic [31:0] ALUResultW, PC_plus4W, InstrW;

  always #5 clk = ~clk;

  mem_wb_stage dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .flush      (flush),
    .valid_m    (valid_m),
    .ready_m    (ready_m),
    .RegWriteM  (RegWriteM),
    .ResultSrcM (ResultSrcM),
    .RdM        (RdM),
    .ALUResultM (ALUResultM),
    .PC_plus4M  (PC_plus4M),
    .InstrM     (InstrM),
    .valid_w    (valid_w),
    .ready_w    (ready_w),
    .RegWriteW  (RegWriteW),
    .ResultSrcW (ResultSrcW),
    .RdW        (RdW),
    .ALUResultW (ALUResultW),
    .PC_plus4W  (PC_plus4W),
    .InstrW     (InstrW)
  );

  pl_t sb[$];
  int  n_cmp = 0;
  int  n_bad = 0;
  bit  mon_en = 1'b0;
  bit  flush_pend = 1'b0;
  bit  out_pend = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  // Reference ready: skid build accepts while fewer than two payloads are held; single-slot
  // build accepts when empty or when the held payload leaves this cycle. Flush forces ready.
  function automatic bit exp_ready();
    if (flush) return 1'b1;
    if (Skid) return sb.size() < 2;
    return (sb.size() == 0) || ready_w;
  endfunction

  function automatic pl_t rand_pl();
    pl_t p;
    p.rw    = 1'($urandom_range(0, 1));
    p.rs    = 2'($urandom_range(0, 3));
    p.rd    = 5'($urandom_range(0, 31));
    p.alu   = $urandom;
    p.pc4   = $urandom;
    p.instr = $urandom;
    return p;
  endfunction

  // Monitor: compare at the falling edge, retire at the rising edge.
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en && n_rst) begin
        bit ev;
        ev = sb.size() > 0;
        chk("valid_w", 32'(valid_w), 32'(ev));
        chk("ready_m", 32'(ready_m), 32'(exp_ready()));
        if (ev) begin
          chk("RegWriteW", 32'(RegWriteW), 32'(sb[0].rw));
          chk("ResultSrcW", 32'(ResultSrcW), 32'(sb[0].rs));
          chk("RdW", 32'(RdW), 32'(sb[0].rd));
          chk("ALUResultW", ALUResultW, sb[0].alu);
          chk("PC_plus4W", PC_plus4W, sb[0].pc4);
          chk("InstrW", InstrW, sb[0].instr);
        end else begin
          chk("bubble RegWriteW", 32'(RegWriteW), 32'd0);
          chk("bubble InstrW", InstrW, Nop);
        end
        out_pend = ev && ready_w;
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      if (mon_en && n_rst) begin
        if (flush_pend) sb.delete();
        else if (out_pend) void'(sb.pop_front());
        flush_pend = 1'b0;
        out_pend   = 1'b0;
      end
    end
  end

  // Driver: one cycle of stimulus; the expected payload is queued once acceptance is known.
  task automatic step(input bit vm, input bit rw, input bit fl, input pl_t p);
    @(posedge clk);
    #1;
    valid_m    = vm;
    ready_w    = rw;
    flush      = fl;
    RegWriteM  = p.rw;
    ResultSrcM = p.rs;
    RdM        = p.rd;
    ALUResultM = p.alu;
    PC_plus4M  = p.pc4;
    InstrM     = p.instr;
    @(negedge clk);
    #2;
    if (fl) flush_pend = 1'b1;
    else if (vm && exp_ready()) sb.push_back(p);
  endtask

  task automatic reset_check(input string tag);
    chk({tag, " valid_w"}, 32'(valid_w), 32'd0);
    chk({tag, " ready_m"}, 32'(ready_m), 32'd0);
    chk({tag, " RegWriteW"}, 32'(RegWriteW), 32'd0);
    chk({tag, " ResultSrcW"}, 32'(ResultSrcW), 32'd0);
    chk({tag, " RdW"}, 32'(RdW), 32'd0);
    chk({tag, " ALUResultW"}, ALUResultW, 32'd0);
    chk({tag, " PC_plus4W"}, PC_plus4W, 32'd0);
    chk({tag, " InstrW"}, InstrW, Nop);
  endtask

  task automatic do_release();
    @(negedge clk);
    #3;
    n_rst = 1'b1;
    #1;
    chk("ready_m before first edge", 32'(ready_m), 32'd0);
    chk("valid_w after release", 32'(valid_w), 32'd0);
    chk("InstrW after release", InstrW, Nop);
    @(posedge clk);
    #1;
    chk("ready_m after first edge", 32'(ready_m), 32'd1);
  endtask

  initial begin
    pl_t p;
    #2;
    reset_check("reset");
    do_release();
    mon_en = 1'b1;

    // Full-rate stream, ALUResult 1..8.
    for (int i = 1; i <= 8; i++) begin
      p = rand_pl();
      p.alu = i;
      step(1'b1, 1'b1, 1'b0, p);
    end
    repeat (2) step(1'b0, 1'b1, 1'b0, rand_pl());

    // Back-pressure while A and B arrive, then drain.
    step(1'b1, 1'b0, 1'b0, rand_pl());
    step(1'b1, 1'b0, 1'b0, rand_pl());
    repeat (2) step(1'b0, 1'b0, 1'b0, rand_pl());
    repeat (3) step(1'b0, 1'b1, 1'b0, rand_pl());

    // Fill, then flush together with a valid input.
    step(1'b1, 1'b0, 1'b0, rand_pl());
    step(1'b1, 1'b0, 1'b0, rand_pl());
    p = rand_pl();
    p.rw = 1'b1;
    p.instr = 32'h0050_0093;
    step(1'b1, 1'b0, 1'b1, p);
    repeat (2) step(1'b0, 1'b1, 1'b0, rand_pl());

    for (int i = 0; i < 300; i++) begin
      step(($urandom % 4) != 0, ($urandom % 3) != 0, ($urandom % 16) == 0, rand_pl());
    end

    // Asynchronous reset in the middle of a stalled stream.
    step(1'b1, 1'b0, 1'b0, rand_pl());
    step(1'b1, 1'b0, 1'b0, rand_pl());
    #1;
    n_rst   = 1'b0;
    valid_m = 1'b0;
    flush   = 1'b0;
    #1;
    reset_check("mid reset");
    sb.delete();
    flush_pend = 1'b0;
    out_pend   = 1'b0;
    repeat (2) @(posedge clk);
    do_release();

    for (int i = 1; i <= 4; i++) begin
      p = rand_pl();
      p.alu = 32'h100 + i;
      step(1'b1, 1'b1, 1'b0, p);
    end
    for (int i = 0; i < 150; i++) begin
      step(($urandom % 3) != 0, ($urandom % 2) != 0, ($urandom % 20) == 0, rand_pl());
    end
    repeat (4) step(1'b0, 1'b1, 1'b0, rand_pl());
    chk("scoreboard drained", 32'(sb.size()), 32'd0);

    mon_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
